mips_pipe_hazard_ctrl: RTL
==========================

// Module: mips_pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline controller for the 5-stage MIPS core: tracks in-flight instructions from EX through
//  NUM_FWD_STAGES later stages, and generates EX operand forward selects, load-use stalls and branch flushes.
//  Also provides performance counters. Replaces the fixed 2-stage forwarding and hazard-detection logic.
// PARAMETERS
//  NUM_FWD_STAGES  2   stages after EX that can forward (pos 1..N); must be >= LOAD_LAT+1
//  LOAD_LAT        1   cycles after EX before a load result is forwardable; drives stall length
//  BR_RESOLVE_EX   0   0: branch resolved in ID, flush IF/ID only; 1: resolved in EX, also bubble ID/EX
//  CNT_W           32  performance counter width
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      synchronous, active-low reset
//  id_valid_i     in   1      ID holds a real instruction
//  id_rs_i        in   5      ID source reg rs
//  id_rt_i        in   5      ID source reg rt
//  id_uses_rs_i   in   1      ID instruction reads rs
//  id_uses_rt_i   in   1      ID instruction reads rt
//  id_regwrite_i  in   1      ID instruction writes a register
//  id_memread_i   in   1      ID instruction is a load
//  id_dst_i       in   5      ID destination register (rd or rt, already muxed)
//  br_redirect_i  in   1      resolving stage redirects the PC this cycle
//  halt_i         in   1      freeze the pipeline and the counters
//  stall_o        out  1      hold PC and IF/ID
//  bubble_o       out  1      load NOP into ID/EX
//  flush_if_o     out  1      squash IF/ID
//  fwd_a_o        out  FW     EX op A source: 0 = regfile, k = stage pos k; FW = $clog2(NUM_FWD_STAGES+1)
//  fwd_b_o        out  FW     EX op B source, same encoding
//  retire_o       out  1      valid instruction leaves pos NUM_FWD_STAGES this cycle
//  cyc_cnt_o      out  CNT_W  non-halted cycles
//  stall_cnt_o    out  CNT_W  load-use stall cycles
//  flush_cnt_o    out  CNT_W  redirect events
//  retire_cnt_o   out  CNT_W  retired instructions
// BEHAVIOUR
//  - Shadow shift register, pos 0 (EX) .. NUM_FWD_STAGES. Each entry holds {valid, regwrite, memread, dst, rs, rt}.
//  - Reset: all entries invalid, all counters 0. All outputs are 0 in the cycle after rst_n is sampled low.
//    Reset mid-operation discards in-flight state with no retire pulses.
//  - Outputs are combinational from the shadow state and current inputs. The shadow advances on clk.
//  - fwd_x_o: picks the smallest k in 1..N where entry k is valid, has regwrite, dst != 0 and dst == EX rs/rt.
//    A load entry qualifies only when k >= LOAD_LAT+1. Otherwise the select is 0. Reg 0 never forwards.
//  - Load-use stall:
//    - Condition: id_valid_i, and a used ID source (nonzero) matches dst of a valid memread entry at pos p <= LOAD_LAT-1.
//    - Effect: stall_o=1 and bubble_o=1. The condition naturally lasts LOAD_LAT-p cycles.
//  - Redirect: br_redirect_i gives flush_if_o=1. It also gives bubble_o=1 when BR_RESOLVE_EX=1.
//    Redirect overrides stall: stall_o=0, and the cycle is not counted as a stall.
//  - Advance when !halt_i:
//    - pos k <= pos k-1.
//    - pos 0 <= ID fields, with valid = id_valid_i & !bubble_o.
//    - retire_o = valid of pos N, before the shift.
//  - halt_i=1: shadow and counters hold. stall_o=1, bubble_o=0, flush_if_o=0, retire_o=0. fwd selects remain valid.
//  - Counters wrap modulo 2^CNT_W. On simultaneous events in one cycle, each applicable counter increments once.
// TESTING
//  - Reset: rst_n=0 for 2 cycles, then 1 -> all outputs 0, counters 0. After N+1 cycles of idle ID, retire_cnt_o=0.
//  - Forwarding:
//    - add r3 then add r4,r3,r3 back-to-back -> fwd_a_o=fwd_b_o=1.
//    - With one independent instr between them -> 2.
//    - With dst=r0 -> 0.
//  - Load-use: lw r5 then add r6,r5,r1, LOAD_LAT=1 -> exactly 1 cycle stall_o=bubble_o=1, then fwd_a_o=2.
//    Same with LOAD_LAT=2, N=3 -> 2 stall cycles, then fwd_a_o=3. stall_cnt_o matches each.
//  - Redirect during stall: load-use and br_redirect_i in the same cycle -> stall_o=0, flush_if_o=1.
//    bubble_o=BR_RESOLVE_EX. flush_cnt_o+1, stall_cnt_o unchanged.
//  - Halt: 4 valid instrs in flight, halt_i=1 for 5 cycles -> retire_o=0 and counters frozen.
//    After release, 4 retire pulses follow in order.
//  - Counter wrap: CNT_W=4, 17 retires -> retire_cnt_o=1.

Source files
------------

// File: rtl/mips_pipe_hazard_ctrl_if.sv
// Hazard controller port bundle. The core's ID/branch side is the master and the
// controller is the slave.
interface mips_pipe_hazard_ctrl_if #(
    parameter int unsigned NUM_FWD_STAGES = 2,
    parameter int unsigned CNT_W          = 32
);
    localparam int unsigned FW = $clog2(NUM_FWD_STAGES + 1);

    logic             id_valid_i;
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rs_i;
    logic             id_uses_rt_i;
    logic             id_regwrite_i;
    logic             id_memread_i;
    logic [4:0]       id_dst_i;
    logic             br_redirect_i;
    logic             halt_i;
    logic             stall_o;
    logic             bubble_o;
    logic             flush_if_o;
    logic [FW-1:0]    fwd_a_o;
    logic [FW-1:0]    fwd_b_o;
    logic             retire_o;
    logic [CNT_W-1:0] cyc_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] retire_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
               id_regwrite_i, id_memread_i, id_dst_i, br_redirect_i, halt_i,
        input  stall_o, bubble_o, flush_if_o, fwd_a_o, fwd_b_o, retire_o,
               cyc_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
               id_regwrite_i, id_memread_i, id_dst_i, br_redirect_i, halt_i,
        output stall_o, bubble_o, flush_if_o, fwd_a_o, fwd_b_o, retire_o,
               cyc_cnt_o, stall_cnt_o, flush_cnt_o, retire_cnt_o
    );
endinterface

// File: rtl/mips_pipe_hazard_ctrl.sv
// Pipeline hazard controller: shadows EX..EX+N, produces forward selects, load-use
// stalls, redirect flushes and performance counters.
module mips_pipe_hazard_ctrl #(
    parameter int unsigned NUM_FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT       = 1,
    parameter bit          BR_RESOLVE_EX  = 1'b0,
    parameter int unsigned CNT_W          = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    mips_pipe_hazard_ctrl_if.slave bus
);
    localparam int N     = int'(NUM_FWD_STAGES);
    localparam int LdLat = int'(LOAD_LAT);
    localparam int FW    = $clog2(N + 1);

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
    } entry_t;

    entry_t [N:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic          load_use;
    logic          stall, bubble, flush, retire;
    logic [FW-1:0] fwd_a, fwd_b;

    // Walk from the oldest stage down so the youngest qualifying producer wins.
    function automatic logic [FW-1:0] fwd_sel(input logic [4:0] src, input entry_t [N:0] sh);
        logic [FW-1:0] sel;
        sel = '0;
        for (int k = N; k >= 1; k--) begin
            if (sh[k].valid && sh[k].regwrite && (sh[k].dst != 5'd0) && (sh[k].dst == src) &&
                (!sh[k].memread || (k >= LdLat + 1))) begin
                sel = FW'(k);
            end
        end
        return sel;
    endfunction

    always_comb begin
        load_use = 1'b0;
        for (int p = 0; p < LdLat; p++) begin
            if (shadow_q[p].valid && shadow_q[p].memread && (shadow_q[p].dst != 5'd0) &&
                ((bus.id_uses_rs_i && (bus.id_rs_i == shadow_q[p].dst)) ||
                 (bus.id_uses_rt_i && (bus.id_rt_i == shadow_q[p].dst)))) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use & bus.id_valid_i;

        fwd_a = fwd_sel(shadow_q[0].rs, shadow_q);
        fwd_b = fwd_sel(shadow_q[0].rt, shadow_q);

        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        retire = 1'b0;
        if (!rst_n) begin
            // Outputs stay quiet while reset is held, so discarded work never retires.
        end else if (bus.halt_i) begin
            stall = 1'b1;
        end else begin
            stall  = load_use & ~bus.br_redirect_i;
            bubble = bus.br_redirect_i ? BR_RESOLVE_EX : load_use;
            flush  = bus.br_redirect_i;
            retire = shadow_q[N].valid;
        end
    end

    always_comb begin
        shadow_d     = shadow_q;
        cyc_cnt_d    = cyc_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (!bus.halt_i) begin
            for (int k = N; k >= 1; k--) begin
                shadow_d[k] = shadow_q[k-1];
            end
            shadow_d[0] = '{valid:    bus.id_valid_i & ~bubble,
                            regwrite: bus.id_regwrite_i,
                            memread:  bus.id_memread_i,
                            dst:      bus.id_dst_i,
                            rs:       bus.id_rs_i,
                            rt:       bus.id_rt_i};
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
            if (stall)  stall_cnt_d  = stall_cnt_q + CNT_W'(1);
            if (flush)  flush_cnt_d  = flush_cnt_q + CNT_W'(1);
            if (retire) retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            cyc_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            shadow_q     <= shadow_d;
            cyc_cnt_q    <= cyc_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.stall_o      = stall;
    assign bus.bubble_o     = bubble;
    assign bus.flush_if_o   = flush;
    assign bus.retire_o     = retire;
    assign bus.fwd_a_o      = fwd_a;
    assign bus.fwd_b_o      = fwd_b;
    assign bus.cyc_cnt_o    = cyc_cnt_q;
    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;
    assign bus.retire_cnt_o = retire_cnt_q;
endmodule
